// File: rtl/dbus_responder_pkg.sv
// Shared types and constants for the dbus responder: FSM state encoding, size codes, strobe type.
// The misalignment helper only takes effect when DBUS_RESP_MISALIGN_CHECK_EN is defined.
package dbus_responder_pkg;

    typedef logic [7:0] strobe_t;

    typedef logic [1:0] dbus_resp_state_t;
    localparam dbus_resp_state_t IDLE = 2'd0;
    localparam dbus_resp_state_t WAIT = 2'd1;
    localparam dbus_resp_state_t RESP = 2'd2;

    localparam logic [2:0] MSIZE1 = 3'd0;
    localparam logic [2:0] MSIZE2 = 3'd1;
    localparam logic [2:0] MSIZE4 = 3'd2;
    localparam logic [2:0] MSIZE8 = 3'd3;

    // Any size code above a double-word is reported as misaligned.
    function automatic logic is_misaligned(input logic [2:0] low, input logic [2:0] size);
        logic mis;
        case (size)
            MSIZE1:  mis = 1'b0;
            MSIZE2:  mis = low[0];
            MSIZE4:  mis = |low[1:0];
            MSIZE8:  mis = |low;
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dbus_resp_ram.sv
// Single-port word RAM with byte-lane writes; the read port is combinational, so a
// write in the same cycle as a read at that index returns the old word.
module dbus_resp_ram
    import dbus_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  strobe_t       be,
    input  logic [AW-1:0] idx,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata
);

    logic [63:0] mem [DEPTH_WORDS];

    assign rdata = mem[idx];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 8; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dbus_responder.sv
// Memory-side dbus endpoint: one request at a time, fixed LATENCY, served from on-chip RAM.
// Optional misaligned-request detection and dresp_err port under DBUS_RESP_MISALIGN_CHECK_EN.
module dbus_responder
    import dbus_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dreq_valid,
    input  logic [63:0] dreq_addr,
    input  logic [2:0]  dreq_size,
    input  strobe_t     dreq_strobe,
    input  logic [63:0] dreq_data,
    output logic        dresp_addr_ok,
    output logic        dresp_data_ok,
    output logic [63:0] dresp_data
`ifdef DBUS_RESP_MISALIGN_CHECK_EN
    ,
    output logic        dresp_err
`endif
);

    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  LAT_LOAD = 4'(LATENCY - 1);

    dbus_resp_state_t state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [63:0]      addr_q, data_q;
    logic [2:0]       size_q;
    strobe_t          strobe_q;
    logic [63:0]      resp_data_q;
    logic             err_q;

    logic [63:0]      req_addr, req_data;
    logic [2:0]       req_size;
    strobe_t          req_strobe;
    logic             misalign;
    logic             accept, resp_load;
    logic             ram_we;
    logic [63:0]      ram_rdata;

    // In IDLE the live request drives the RAM so LATENCY=1 can read on the accept edge.
    always_comb begin
        if (state_q == IDLE) begin
            req_addr   = dreq_addr;
            req_size   = dreq_size;
            req_strobe = dreq_strobe;
            req_data   = dreq_data;
        end else begin
            req_addr   = addr_q;
            req_size   = size_q;
            req_strobe = strobe_q;
            req_data   = data_q;
        end
    end

`ifdef DBUS_RESP_MISALIGN_CHECK_EN
    assign misalign = is_misaligned(req_addr[2:0], req_size);
    logic unused_bits;
    assign unused_bits = ^{req_addr[63:AW+3]};
`else
    assign misalign = 1'b0;
    logic unused_bits;
    assign unused_bits = ^{req_addr[63:AW+3], req_addr[2:0], req_size};
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        dresp_addr_ok = 1'b0;
        case (state_q)
            IDLE: begin
                dresp_addr_ok = dreq_valid;
                if (dreq_valid) begin
                    cnt_d   = LAT_LOAD;
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign accept        = (state_q == IDLE) && dreq_valid;
    assign resp_load     = (state_d == RESP) && (state_q != RESP);
    assign ram_we        = (state_q == RESP) && !misalign;
    assign dresp_data_ok = (state_q == RESP);
    assign dresp_data    = resp_data_q;
`ifdef DBUS_RESP_MISALIGN_CHECK_EN
    assign dresp_err     = err_q;
`else
    logic unused_err;
    assign unused_err = err_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            size_q      <= '0;
            strobe_q    <= '0;
            data_q      <= '0;
            resp_data_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q   <= dreq_addr;
                size_q   <= dreq_size;
                strobe_q <= dreq_strobe;
                data_q   <= dreq_data;
            end
            if (resp_load) begin
                resp_data_q <= misalign ? 64'd0 : ram_rdata;
            end
            err_q <= resp_load && misalign;
        end
    end

    dbus_resp_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (req_strobe),
        .idx   (req_addr[AW+2:3]),
        .wdata (req_data),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_dbus_responder.sv
// Self-checking bench for dbus_responder: directed table, back-to-back, reset abort, random traffic.
module tb_dbus_responder;

    localparam int unsigned DEPTH   = 1024;
    localparam int unsigned LATENCY = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_addr_ok;
    logic        dresp_data_ok;
    logic [63:0] dresp_data;
    logic        err_sig;

    int errors = 0;
    int checks = 0;

    logic [63:0] mdl [DEPTH];

    always #5 clk = ~clk;

    dbus_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LATENCY)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .dreq_valid    (dreq_valid),
        .dreq_addr     (dreq_addr),
        .dreq_size     (dreq_size),
        .dreq_strobe   (dreq_strobe),
        .dreq_data     (dreq_data),
        .dresp_addr_ok (dresp_addr_ok),
        .dresp_data_ok (dresp_data_ok),
        .dresp_data    (dresp_data)
`ifdef DBUS_RESP_MISALIGN_CHECK_EN
        ,
        .dresp_err     (err_sig)
`endif
    );

`ifndef DBUS_RESP_MISALIGN_CHECK_EN
    assign err_sig = 1'b0;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int midx(input logic [63:0] a);
        return int'((a >> 3) % DEPTH);
    endfunction

    function automatic bit model_mis(input logic [63:0] a, input logic [2:0] s);
`ifdef DBUS_RESP_MISALIGN_CHECK_EN
        if (s > 3) return 1'b1;
        return (a % (64'd1 << s)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    // Expected response from the model, then apply the write to it.
    task automatic model_req(input logic [63:0] a, input logic [2:0] s, input logic [7:0] st,
                             input logic [63:0] d, output logic [63:0] ed, output logic ee);
        int i;
        i  = midx(a);
        ee = model_mis(a, s);
        ed = ee ? 64'd0 : mdl[i];
        if (!ee) begin
            for (int b = 0; b < 8; b++) begin
                if (st[b]) mdl[i][8*b +: 8] = d[8*b +: 8];
            end
        end
    endtask

    // One complete transaction; returns response data/error and checks handshake timing.
    task automatic do_req(input logic [63:0] a, input logic [2:0] s, input logic [7:0] st,
                          input logic [63:0] d, output logic [63:0] rd, output logic re);
        int  n;
        bit  seen;
        @(negedge clk);
        dreq_valid  = 1'b1;
        dreq_addr   = a;
        dreq_size   = s;
        dreq_strobe = st;
        dreq_data   = d;
        #1;
        check("addr_ok_on_request", 64'(dresp_addr_ok), 64'd1);
        @(posedge clk);
        n    = 0;
        seen = 0;
        while (!seen && n < 64) begin
            @(negedge clk);
            #1;
            n++;
            if (dresp_data_ok) seen = 1;
            else if (dresp_addr_ok) check("addr_ok_while_busy", 64'd1, 64'd0);
        end
        check("data_ok_latency", 64'(n), 64'(LATENCY));
        rd = dresp_data;
        re = err_sig;
        dreq_valid = 1'b0;
    endtask

    typedef struct {
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [63:0] exp_data;
        logic        exp_err;
        bit          chk_data;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [63:0] rd, ed, a, d, hi;
        logic        re, ee;
        logic [2:0]  s;
        logic [7:0]  st;
        bit          bad;

        reset       = 1'b0;
        dreq_valid  = 1'b0;
        dreq_addr   = '0;
        dreq_size   = '0;
        dreq_strobe = '0;
        dreq_data   = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_addr_ok", 64'(dresp_addr_ok), 64'd0);
        check("reset_data_ok", 64'(dresp_data_ok), 64'd0);
        check("reset_data", dresp_data, 64'd0);
        check("reset_err", 64'(err_sig), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Known contents for the first 16 words.
        for (int i = 0; i < 16; i++) begin
            d = {32'hD0D0_0000 | 32'(i), 32'h5A5A_0000 | 32'(i)};
            do_req(64'(i * 8), 3'd3, 8'hFF, d, rd, re);
            model_req(64'(i * 8), 3'd3, 8'hFF, d, ed, ee);
        end

        vecs.push_back('{64'h10, 3'd3, 8'hFF, 64'h1122334455667788, 64'hD0D0_0002_5A5A_0002, 0, 1});
        vecs.push_back('{64'h10, 3'd3, 8'h00, 64'h0, 64'h1122334455667788, 0, 1});
        vecs.push_back('{64'h18, 3'd3, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hD0D0_0003_5A5A_0003, 0, 1});
        vecs.push_back('{64'h18, 3'd3, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1});
        vecs.push_back('{64'h18, 3'd3, 8'h00, 64'h0, 64'hFFFFFFFF_BBBBBBBB, 0, 1});
        vecs.push_back('{64'h10 + 64'(DEPTH * 8), 3'd3, 8'hFF, 64'hCAFE_F00D_1234_5678,
                         64'h1122334455667788, 0, 1});
        vecs.push_back('{64'h10, 3'd3, 8'h00, 64'h0, 64'hCAFE_F00D_1234_5678, 0, 1});
`ifdef DBUS_RESP_MISALIGN_CHECK_EN
        vecs.push_back('{64'h22, 3'd2, 8'h00, 64'h0, 64'h0, 1, 1});
        vecs.push_back('{64'h24, 3'd3, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0, 1, 1});
        vecs.push_back('{64'h20, 3'd3, 8'h00, 64'h0, 64'hD0D0_0004_5A5A_0004, 0, 1});
        vecs.push_back('{64'h20, 3'd5, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0, 1, 1});
        vecs.push_back('{64'h20, 3'd3, 8'h00, 64'h0, 64'hD0D0_0004_5A5A_0004, 0, 1});
`endif
        foreach (vecs[k]) begin
            do_req(vecs[k].addr, vecs[k].size, vecs[k].strobe, vecs[k].data, rd, re);
            model_req(vecs[k].addr, vecs[k].size, vecs[k].strobe, vecs[k].data, ed, ee);
            if (vecs[k].chk_data) check($sformatf("vec%0d_data", k), rd, vecs[k].exp_data);
            check($sformatf("vec%0d_err", k), 64'(re), 64'(vecs[k].exp_err));
        end

        // Back-to-back reads with valid held high.
        @(negedge clk);
        dreq_valid  = 1'b1;
        dreq_addr   = 64'h10;
        dreq_size   = 3'd3;
        dreq_strobe = 8'h00;
        dreq_data   = '0;
        for (int k = 0; k < 3 * (LATENCY + 1); k++) begin
            #1;
            check($sformatf("b2b_addr_ok_c%0d", k), 64'(dresp_addr_ok),
                  64'((k % (LATENCY + 1)) == 0));
            check($sformatf("b2b_data_ok_c%0d", k), 64'(dresp_data_ok),
                  64'((k % (LATENCY + 1)) == LATENCY));
            if (dresp_data_ok) check("b2b_data", dresp_data, mdl[2]);
            @(negedge clk);
        end
        dreq_valid = 1'b0;
        repeat (LATENCY + 1) @(negedge clk);

        // Reset one cycle after accepting a write to 0x20: nothing committed, no data_ok.
        dreq_valid  = 1'b1;
        dreq_addr   = 64'h20;
        dreq_size   = 3'd3;
        dreq_strobe = 8'hFF;
        dreq_data   = 64'hDEAD_BEEF_DEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        reset      = 1'b0;
        dreq_valid = 1'b0;
        #1;
        check("abort_data_ok_in_reset", 64'(dresp_data_ok), 64'd0);
        check("abort_data_in_reset", dresp_data, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        bad   = 0;
        for (int k = 0; k < LATENCY + 3; k++) begin
            #1;
            if (dresp_data_ok) bad = 1;
            @(negedge clk);
        end
        check("abort_no_data_ok", 64'(bad), 64'd0);
        do_req(64'h20, 3'd3, 8'h00, 64'h0, rd, re);
        model_req(64'h20, 3'd3, 8'h00, 64'h0, ed, ee);
        check("abort_word_unchanged", rd, 64'hD0D0_0004_5A5A_0004);

        // Random traffic against the model.
        for (int k = 0; k < 60; k++) begin
            hi = {$urandom, $urandom};
            hi = (hi >> (($clog2(DEPTH)) + 3)) << (($clog2(DEPTH)) + 3);
`ifdef DBUS_RESP_MISALIGN_CHECK_EN
            s = 3'($urandom_range(0, 7));
`else
            s = 3'($urandom_range(0, 3));
`endif
            a = hi | 64'($urandom_range(0, 15) * 8) | 64'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1 && s <= 3) a = a & ~((64'd1 << s) - 64'd1);
            st = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom);
            d  = {$urandom, $urandom};
            do_req(a, s, st, d, rd, re);
            model_req(a, s, st, d, ed, ee);
            check($sformatf("rand%0d_data", k), rd, ed);
            check($sformatf("rand%0d_err", k), 64'(re), 64'(ee));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dbus_responder.md
# dbus_responder

Data-bus responder for the pipelined core: the memory-side end of the dbus that the memory stage drives with address, size and byte strobe. It accepts one request at a time and serves it from an on-chip word-organised RAM after a fixed, parameterised latency, returning read data or committing byte-lane writes. It replaces the external memory model in core-level simulation and gives the memory stage a deterministic multi-cycle bus to stall against.

## Interface
- DEPTH_WORDS, 1024: RAM depth in 64-bit words, power of two.
- LATENCY, 2: cycles from request acceptance to data_ok, range 1..15.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- dreq_valid  in  1  request present; held with all fields stable until data_ok.
- dreq_addr  in  64  byte address.
- dreq_size  in  3  0=byte, 1=half, 2=word, 3=double.
- dreq_strobe  in  8  byte-lane write enables; 0 means read.
- dreq_data  in  64  write data, lane-aligned to addr[2:0].
- dresp_addr_ok  out  1  request accepted this cycle.
- dresp_data_ok  out  1  response valid this cycle, one-cycle pulse.
- dresp_data  out  64  full 64-bit word at the addressed index.
- dresp_err  out  1  misaligned request flag; present only with DBUS_RESP_MISALIGN_CHECK_EN.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: dresp_addr_ok = dreq_valid (combinational). On acceptance, capture addr, size, strobe and data; load counter with LATENCY-1; go to WAIT, or straight to RESP if LATENCY=1.
- WAIT: decrement counter each cycle; at 0 go to RESP. dresp_addr_ok stays 0.
- RESP: dresp_data_ok=1; dresp_data = word before any write; commit write lanes where strobe bit set; go to IDLE.
- Index = addr[log2(DEPTH_WORDS)+2:3]; higher address bits ignored (aliasing wrap-around).
- Read and write share one flow; strobe==0 leaves RAM untouched.
- Captured fields are used; input changes during WAIT/RESP are ignored.
- Initiator must not reassert a new request until the cycle after data_ok; IDLE re-entry permits back-to-back acceptance on the following cycle.

## Timing
- Reset: state IDLE, counter 0, dresp_addr_ok, dresp_data_ok, dresp_data, dresp_err all 0. RAM contents not reset.
- Accept at cycle T -> data_ok at T+LATENCY; write visible to a request accepted at T+LATENCY+1 or later.
- Throughput: one request per LATENCY+1 cycles.
- Reset asserted in WAIT or RESP: transaction aborted, no write committed, no data_ok.
- dresp_data registered, valid only while dresp_data_ok=1; holds last value otherwise.

## Configuration
- DBUS_RESP_MISALIGN_CHECK_EN defined: request whose addr is not a multiple of 2^size is accepted normally, no RAM write, RESP returns dresp_data=0 with dresp_err=1 (pulse with data_ok). dreq_size>3 is treated as misaligned.
- Undefined: no dresp_err port; addr[2:0] and size ignored for access, strobe applied as given.

## Structure
- Shared package: dbus_resp_state_t enum (IDLE/WAIT/RESP), size encoding constants MSIZE1/2/4/8, strobe_t reused from common.
- Sub-module dbus_resp_ram: single-port DEPTH_WORDS x 64 RAM, synchronous byte-lane write, read of same index returning old data.
- Top holds FSM, capture registers, latency counter, alignment check.

## Test plan
- Write addr 0x10, strobe 0xFF, data 0x1122334455667788, then read 0x10 -> read data_ok exactly LATENCY cycles after its addr_ok, data 0x1122334455667788.
- Write addr 0x18 strobe 0x0F data 0xAAAAAAAA_BBBBBBBB over prior 0xFFFF..FF, read -> 0xFFFFFFFF_BBBBBBBB.
- Back-to-back read requests, valid held high -> addr_ok pulses every LATENCY+1 cycles, each with one data_ok.
- Write to addr 0x10 + DEPTH_WORDS*8, read 0x10 -> aliased data returned.
- Reset low one cycle after accepting write 0x20 -> no data_ok; later read 0x20 returns original contents.
- With macro: read size=2 at addr 0x22 -> data_ok with dresp_err=1, data 0; write size=3 at 0x24 leaves RAM unchanged.
